// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   DEFAULT_WIDTH : default operand width in bits
//   OP_MUL/OP_DIV : encoding of the op input
//   state_t       : controller states (IDLE, RUN, DONE)
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiplier (shift-add) and divider (restoring),
// one iteration per clock for WIDTH clocks.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   start       : request a new operation (accepted in IDLE or DONE)
//   op          : OP_MUL (0) or OP_DIV (1)
//   a, b        : multiplicand/multiplier or dividend/divisor
//   busy        : high while iterating (RUN)
//   done        : one-cycle pulse while in DONE; hi/lo hold the new result
//   hi, lo      : product upper/lower half, or remainder/quotient
//   div_by_zero : last completed divide had a zero divisor
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic             op_q;
  logic [WIDTH-1:0] opb;
  // Working register: {upper (WIDTH+1 bits), lower (WIDTH bits)}.
  // Multiply: upper = partial product with carry, lower = remaining multiplier bits.
  // Divide:   upper = partial remainder,          lower = dividend/quotient bits.
  logic [2*WIDTH:0] work;
  logic [2*WIDTH:0] work_next;

  logic accept;
  logic zero_div;
  logic last_iter;

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    accept    = (state == IDLE || state == DONE) && start;
    zero_div  = (op == OP_DIV) && (b == '0);
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // One iteration of the selected algorithm.
  always_comb begin
    sum       = '0;
    shifted   = '0;
    diff      = '0;
    work_next = work;
    if (op_q == OP_MUL) begin
      // Add the multiplicand into the upper half when the current multiplier
      // bit is set, then shift the whole register right (carry lands in bit 2W-1).
      sum       = work[2*WIDTH:WIDTH] + (work[0] ? {1'b0, opb} : '0);
      work_next = {1'b0, sum, work[WIDTH-1:1]};
    end else begin
      // Shift the next dividend bit into the remainder; keep the subtraction
      // only when it does not go negative, recording a quotient bit of 1.
      shifted   = {work[2*WIDTH-1:0], 1'b0};
      diff      = shifted[2*WIDTH:WIDTH] - {1'b0, opb};
      if (shifted[2*WIDTH:WIDTH] >= {1'b0, opb})
        work_next = {diff, shifted[WIDTH-1:1], 1'b1};
      else
        work_next = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = zero_div ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter)
          state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start)
          state_next = zero_div ? DONE : RUN;
        else
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      op_q        <= OP_MUL;
      opb         <= '0;
      work        <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= op;
      opb  <= b;
      work <= {{(WIDTH + 1){1'b0}}, a};
      // Zero divisor bypasses RUN, so its result is written on acceptance.
      if (zero_div) begin
        hi          <= a;
        lo          <= '1;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      work <= work_next;
      cnt  <= cnt + 1'b1;
      if (last_iter) begin
        hi          <= work_next[2*WIDTH-1:WIDTH];
        lo          <= work_next[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        div_by_zero;

  int n_cmp;
  int n_bad;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one operation; lat = cycles after the acceptance edge until done is seen.
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output int bcnt);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 64) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi !== 16'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0000", hi); end
    n_cmp++; if (lo !== 16'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0000", lo); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mul_small();
    int lat, bcnt;
    run_op(1'b0, 16'd3, 16'd5, lat, bcnt);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL mul3x5_latency got %0d want 16", lat); end
    n_cmp++; if (bcnt !== 16) begin n_bad++; $display("FAIL mul3x5_busy_cycles got %0d want 16", bcnt); end
    n_cmp++; if (hi !== 16'h0000) begin n_bad++; $display("FAIL mul3x5_hi got %h want 0000", hi); end
    n_cmp++; if (lo !== 16'h000F) begin n_bad++; $display("FAIL mul3x5_lo got %h want 000f", lo); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mul3x5_done_pulse got %b want 0", done); end
    n_cmp++; if (lo !== 16'h000F) begin n_bad++; $display("FAIL mul3x5_lo_hold got %h want 000f", lo); end
  endtask

  task automatic test_mul_max();
    int lat, bcnt;
    run_op(1'b0, 16'hFFFF, 16'hFFFF, lat, bcnt);
    n_cmp++; if (hi !== 16'hFFFE) begin n_bad++; $display("FAIL mulmax_hi got %h want fffe", hi); end
    n_cmp++; if (lo !== 16'h0001) begin n_bad++; $display("FAIL mulmax_lo got %h want 0001", lo); end
    run_op(1'b0, 16'h1234, 16'h0100, lat, bcnt);
    n_cmp++; if ({hi, lo} !== 32'h0012_3400) begin n_bad++; $display("FAIL mul1234x100 got %h want 00123400", {hi, lo}); end
  endtask

  task automatic test_div();
    int lat, bcnt;
    run_op(1'b1, 16'd100, 16'd7, lat, bcnt);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL div100_7_latency got %0d want 16", lat); end
    n_cmp++; if (lo !== 16'd14) begin n_bad++; $display("FAIL div100_7_q got %0d want 14", lo); end
    n_cmp++; if (hi !== 16'd2) begin n_bad++; $display("FAIL div100_7_r got %0d want 2", hi); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL div100_7_dbz got %b want 0", div_by_zero); end
    run_op(1'b1, 16'hFFFF, 16'h0001, lat, bcnt);
    n_cmp++; if ({hi, lo} !== 32'h0000_FFFF) begin n_bad++; $display("FAIL divffff_1 got %h want 0000ffff", {hi, lo}); end
    run_op(1'b1, 16'd5, 16'd9, lat, bcnt);
    n_cmp++; if ({hi, lo} !== 32'h0005_0000) begin n_bad++; $display("FAIL div5_9 got %h want 00050000", {hi, lo}); end
    run_op(1'b1, 16'hFFFF, 16'h8000, lat, bcnt);
    n_cmp++; if ({hi, lo} !== 32'h7FFF_0001) begin n_bad++; $display("FAIL divffff_8000 got %h want 7fff0001", {hi, lo}); end
  endtask

  task automatic test_div_by_zero();
    int lat, bcnt;
    run_op(1'b1, 16'h1234, 16'h0000, lat, bcnt);
    // Done is visible in the very cycle after the accepting edge.
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL dbz_latency got %0d want 0", lat); end
    n_cmp++; if (bcnt !== 0) begin n_bad++; $display("FAIL dbz_busy_cycles got %0d want 0", bcnt); end
    n_cmp++; if (hi !== 16'h1234) begin n_bad++; $display("FAIL dbz_hi got %h want 1234", hi); end
    n_cmp++; if (lo !== 16'hFFFF) begin n_bad++; $display("FAIL dbz_lo got %h want ffff", lo); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dbz_done_pulse got %b want 0", done); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dbz_flag_hold got %b want 1", div_by_zero); end
    run_op(1'b0, 16'd1, 16'd1, lat, bcnt);
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dbz_cleared got %b want 0", div_by_zero); end
    n_cmp++; if (lo !== 16'd1) begin n_bad++; $display("FAIL mul1x1_lo got %h want 0001", lo); end
  endtask

  task automatic test_back_to_back();
    int total;
    int lat;
    // Previous result is hi=0, lo=1.
    start = 1'b1; op = 1'b0; a = 16'd10; b = 16'd10;
    step();
    start = 1'b0;
    total = 0;
    for (int i = 0; i < 5; i++) begin step(); total++; end
    start = 1'b1; op = 1'b1; a = 16'd1; b = 16'd1;
    step(); total++;
    start = 1'b0; a = 16'hAAAA; b = 16'h5555;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_ignored_start_busy got %b want 1", busy); end
    n_cmp++; if ({hi, lo} !== 32'h0000_0001) begin n_bad++; $display("FAIL b2b_hold_midrun got %h want 00000001", {hi, lo}); end
    while (!done && total < 64) begin step(); total++; end
    n_cmp++; if (total !== 16) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 16", total); end
    n_cmp++; if ({hi, lo} !== 32'h0000_0064) begin n_bad++; $display("FAIL b2b_first_result got %h want 00000064", {hi, lo}); end
    start = 1'b1; op = 1'b0; a = 16'd7; b = 16'd6;
    step();
    start = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL b2b_relaunch busy_done got %b want 10", {busy, done}); end
    n_cmp++; if (lo !== 16'd100) begin n_bad++; $display("FAIL b2b_hold_second got %0d want 100", lo); end
    lat = 0;
    while (!done && lat < 64) begin step(); lat++; end
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 16", lat); end
    n_cmp++; if (lo !== 16'd42) begin n_bad++; $display("FAIL b2b_7x6 got %0d want 42", lo); end
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat, bcnt;
    start = 1'b1; op = 1'b0; a = 16'd9; b = 16'd9;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if ({hi, lo} !== 32'h0) begin n_bad++; $display("FAIL rstmid_hilo got %h want 00000000", {hi, lo}); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", done); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (done || busy) seen++;
      step();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d active cycles want 0", seen); end
    run_op(1'b0, 16'd2, 16'd2, lat, bcnt);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL rstmid_2x2_latency got %0d want 16", lat); end
    n_cmp++; if (lo !== 16'd4) begin n_bad++; $display("FAIL rstmid_2x2 got %0d want 4", lo); end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; op = 1'b0; a = 16'd3; b = 16'd3;
    step();
    rst_n = 1'b1; start = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL rst_priority got %b want 00", {busy, done}); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_mul_small();
    test_mul_max();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
